kyogenrv_avm_dmem_bridge: RTL

//  Bridges KyogenRV data-memory req/ack port to one Avalon-MM master (pipelined-read capable).

---
 rtl/kyogenrv_avm_pkg.sv | 18 +
 rtl/kyogenrv_avm_timeout.sv | 35 +++
 rtl/kyogenrv_avm_dmem_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/kyogenrv_avm_pkg.sv
// Shared types and constants for the KyogenRV dmem -> Avalon-MM bridge.
package kyogenrv_avm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_CMD  = 3'd3,
    ST_RESP    = 3'd4
  } bridge_state_e;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

  // Wide enough for any sensible data width; callers slice off DATA_W/8 lanes.
  localparam int unsigned              BE_MAX_W    = 64;
  localparam logic [BE_MAX_W-1:0]      BE_ALL_ONES = '1;

endpackage

// File: rtl/kyogenrv_avm_timeout.sv
// Saturating busy-cycle counter; expire flags the cycle that completes the
// TIMEOUT_CYC-th busy cycle so the caller can abort on that edge.
module kyogenrv_avm_timeout
  import kyogenrv_avm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned       CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  LAST  = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Count busy cycles, holding at LIMIT so the value can never wrap to zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  // A zero limit disables the abort entirely.
  assign expire = (TIMEOUT_CYC != 0) && enable && (count >= LAST);

endmodule

// File: rtl/kyogenrv_avm_dmem_bridge.sv
// KyogenRV data-memory req/ack port to a single Avalon-MM master.
// One transaction in flight; a hung slave is aborted by the timeout counter.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | no transaction; write request wins over read request
//   ST_RD_CMD  | avm_read asserted, waiting for slave to drop waitrequest
//   ST_RD_DATA | read accepted, waiting for readdatavalid
//   ST_WR_CMD  | avm_write asserted, waiting for slave to drop waitrequest
//   ST_RESP    | single cycle: ack (and maybe bus_error) presented to CPU
module kyogenrv_avm_dmem_bridge
  import kyogenrv_avm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter bit          ALIGN_ADDR  = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cpu_r_req,
  input  logic                cpu_w_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_byteenable,
  output logic                cpu_r_ack,
  output logic [DATA_W-1:0]   cpu_r_data,
  output logic                cpu_w_ack,
  output logic                cpu_waitrequest,
  output logic                cpu_bus_error,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam int unsigned BE_W = DATA_W / 8;

  bridge_state_e     state;
  logic              expire;
  logic [ADDR_W-1:0] addr_aligned;

  // Word-align the CPU address before it is latched onto the bus.
  always_comb begin
    addr_aligned = cpu_addr;
    if (ALIGN_ADDR) begin
      addr_aligned[1:0] = 2'b00;
    end
  end

  kyogenrv_avm_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .enable  ((state == ST_RD_CMD) || (state == ST_RD_DATA) || (state == ST_WR_CMD)),
    .expire  (expire)
  );

  // Released only in the response cycle so the CPU sees ack and no stall together.
  assign cpu_waitrequest = (cpu_r_req | cpu_w_req) & (state != ST_RESP);

  // Transaction FSM together with every registered bus and CPU-side output.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cpu_r_ack      <= 1'b0;
      cpu_w_ack      <= 1'b0;
      cpu_bus_error  <= 1'b0;
      cpu_r_data     <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
    end else begin
      cpu_r_ack     <= 1'b0;
      cpu_w_ack     <= 1'b0;
      cpu_bus_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_w_req) begin
            avm_address    <= addr_aligned;
            avm_writedata  <= cpu_wdata;
            avm_byteenable <= cpu_byteenable;
            avm_write      <= 1'b1;
            state          <= ST_WR_CMD;
          end else if (cpu_r_req) begin
            avm_address    <= addr_aligned;
            avm_byteenable <= BE_ALL_ONES[BE_W-1:0];
            avm_read       <= 1'b1;
            state          <= ST_RD_CMD;
          end
        end
        ST_RD_CMD: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_RD_DATA;
          end else if (expire) begin
            avm_read      <= 1'b0;
            cpu_r_data    <= '0;
            cpu_r_ack     <= 1'b1;
            cpu_bus_error <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RD_DATA: begin
          if (avm_readdatavalid) begin
            cpu_r_data <= avm_readdata;
            cpu_r_ack  <= 1'b1;
            state      <= ST_RESP;
          end else if (expire) begin
            cpu_r_data    <= '0;
            cpu_r_ack     <= 1'b1;
            cpu_bus_error <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_WR_CMD: begin
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            cpu_w_ack <= 1'b1;
            state     <= ST_RESP;
          end else if (expire) begin
            avm_write     <= 1'b0;
            cpu_w_ack     <= 1'b1;
            cpu_bus_error <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
